// File: rtl/core_pkg.sv
// Shared types and constants for the NPC core sequencer.
//   state_e      : sequencer FSM states
//   OPC_*/F3_*   : instruction field encodings recognised by core_decode
//   HALT_*       : halt_code encodings reported by core_seq
package core_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetchReq  = 3'd1,
    StFetchWait = 3'd2,
    StDecode    = 3'd3,
    StExec      = 3'd4,
    StWb        = 3'd5,
    StHalt      = 3'd6
  } state_e;

  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [2:0]  F3_ADDI     = 3'b000;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_EBREAK  = 2'b01;
  localparam logic [1:0] HALT_ILLEGAL = 2'b10;
  localparam logic [1:0] HALT_TIMEOUT = 2'b11;

endpackage

// File: rtl/core_decode.sv
// Combinational instruction classifier.
//   ir        : latched instruction word
//   is_addi   : OP-IMM with funct3 ADDI
//   is_ebreak : exact ebreak encoding
//   illegal   : anything the sequencer does not implement
//   rd_nz     : destination register is not x0
module core_decode
  import core_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_addi,
  output logic        is_ebreak,
  output logic        illegal,
  output logic        rd_nz
);

  always_comb begin
    is_ebreak = (ir == INST_EBREAK);
    is_addi   = (ir[6:0] == OPC_OP_IMM) && (ir[14:12] == F3_ADDI);
    illegal   = !is_addi && !is_ebreak;
    rd_nz     = |ir[11:7];
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the NPC core.
//   clk, reset (sync, active-low), run      : clock, reset, start request (IDLE only)
//   imem_req_valid/ready, imem_addr         : fetch request handshake, address = pc
//   imem_rsp_valid, imem_rsp_data           : instruction response
//   exu_npc                                 : next PC from datapath, taken in WB
//   ir, pc                                  : latched instruction, current PC
//   rf_ren, rf_wen                          : register-file strobes (one pulse per instruction)
//   halt, halt_code                         : sticky halt flag and reason
//   cycle_cnt, instret                      : active-cycle and retired-instruction counters
module core_seq
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     TIMEOUT  = 255,
  parameter int unsigned     CNT_W    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic [XLEN-1:0]  exu_npc,
  output logic [31:0]      ir,
  output logic [XLEN-1:0]  pc,
  output logic             rf_ren,
  output logic             rf_wen,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned     TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic [1:0]        halt_code_q, halt_code_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic is_addi, is_ebreak, illegal, rd_nz;

  core_decode u_decode (
    .ir        (ir_q),
    .is_addi   (is_addi),
    .is_ebreak (is_ebreak),
    .illegal   (illegal),
    .rd_nz     (rd_nz)
  );

  // Value the wait counter would take this cycle; timeout fires when it reaches TIMEOUT,
  // so at most TIMEOUT cycles are spent in FETCH_WAIT.
  assign to_inc = to_q + TO_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    to_d        = to_q;
    halt_code_d = halt_code_q;
    instret_d   = instret_q;
    cycle_d     = (state_q != StIdle && state_q != StHalt) ? cycle_q + CNT_W'(1) : cycle_q;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetchReq;
      end
      StFetchReq: begin
        if (imem_req_ready) begin
          state_d = StFetchWait;
          to_d    = '0;
        end
      end
      StFetchWait: begin
        // A response in the timeout cycle still wins.
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = StDecode;
        end else begin
          to_d = to_inc;
          if (to_inc == TO_LIMIT) begin
            state_d     = StHalt;
            halt_code_d = HALT_TIMEOUT;
          end
        end
      end
      StDecode: begin
        if (is_ebreak) begin
          state_d     = StHalt;
          halt_code_d = HALT_EBREAK;
          instret_d   = instret_q + CNT_W'(1);
        end else if (illegal) begin
          state_d     = StHalt;
          halt_code_d = HALT_ILLEGAL;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StWb;
      end
      StWb: begin
        pc_d      = exu_npc;
        instret_d = instret_q + CNT_W'(1);
        state_d   = StFetchReq;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      to_q        <= '0;
      halt_code_q <= HALT_NONE;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      to_q        <= to_d;
      halt_code_q <= halt_code_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
    end
  end

  // Outputs are state decodes or register copies only; no imem input reaches them.
  always_comb begin
    imem_req_valid = (state_q == StFetchReq);
    imem_addr      = pc_q;
    pc             = pc_q;
    ir             = ir_q;
    rf_ren         = (state_q == StDecode) && is_addi;
    rf_wen         = (state_q == StWb) && rd_nz;
    halt           = (state_q == StHalt);
    halt_code      = halt_code_q;
    cycle_cnt      = cycle_q;
    instret        = instret_q;
  end

endmodule

// File: tb/tb_core_seq.sv
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_core_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] exu_npc;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        rf_ren;
  logic        rf_wen;
  logic        halt;
  logic [1:0]  halt_code;
  logic [63:0] cycle_cnt;
  logic [63:0] instret;

  int n_assert = 0;
  int n_fail   = 0;

  core_seq #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000),
    .TIMEOUT  (4),
    .CNT_W    (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .exu_npc        (exu_npc),
    .ir             (ir),
    .pc             (pc),
    .rf_ren         (rf_ren),
    .rf_wen         (rf_wen),
    .halt           (halt),
    .halt_code      (halt_code),
    .cycle_cnt      (cycle_cnt),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ok(input string tag, input bit ok, input logic [63:0] obs,
                        input logic [63:0] exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    reset          = 1'b0;
    step();
    reset          = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    run            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    exu_npc        = 32'h8000_0004;
    step();
    do_reset();

    // Reset state
    chk_ok("rst_req_valid", imem_req_valid === 1'b0, 64'(imem_req_valid), 64'd0);
    chk_ok("rst_pc", pc === 32'h8000_0000, 64'(pc), 64'h8000_0000);
    chk_ok("rst_ir", ir === 32'h0, 64'(ir), 64'd0);
    chk_ok("rst_halt", halt === 1'b0, 64'(halt), 64'd0);
    chk_ok("rst_halt_code", halt_code === 2'b00, 64'(halt_code), 64'd0);
    chk_ok("rst_cycle", cycle_cnt === 64'd0, cycle_cnt, 64'd0);
    chk_ok("rst_instret", instret === 64'd0, instret, 64'd0);
    `CHK("rst_strobes", {rf_ren, rf_wen}, 2'b00);

    // addi x1,x0,5 with minimum latency
    run = 1'b1; imem_req_ready = 1'b1;
    step();                                   // FETCH_REQ
    run = 1'b0;
    chk_ok("addi_req_valid", imem_req_valid === 1'b1, 64'(imem_req_valid), 64'd1);
    chk_ok("addi_req_addr", imem_addr === 32'h8000_0000, 64'(imem_addr), 64'h8000_0000);
    step();                                   // FETCH_WAIT
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    `CHK("addi_wait_req_valid", imem_req_valid, 1'b0);
    step();                                   // DECODE
    imem_rsp_valid = 1'b0;
    chk_ok("addi_ir", ir === 32'h0050_0093, 64'(ir), 64'h0050_0093);
    chk_ok("addi_rf_ren", rf_ren === 1'b1, 64'(rf_ren), 64'd1);
    step();                                   // EXEC
    `CHK("addi_exec_strobes", {rf_ren, rf_wen}, 2'b00);
    step();                                   // WB
    chk_ok("addi_rf_wen", rf_wen === 1'b1, 64'(rf_wen), 64'd1);
    `CHK("addi_wb_pc", pc, 32'h8000_0000);
    step();                                   // FETCH_REQ of next instruction
    chk_ok("addi_pc", pc === 32'h8000_0004, 64'(pc), 64'h8000_0004);
    chk_ok("addi_instret", instret === 64'd1, instret, 64'd1);
    chk_ok("addi_cycle", cycle_cnt === 64'd5, cycle_cnt, 64'd5);
    `CHK("addi_wen_off", rf_wen, 1'b0);

    // Request stall for 3 cycles; a stray response during the stall is ignored
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
    for (int i = 0; i < 3; i++) begin
      chk_ok("stall_req_valid", imem_req_valid === 1'b1, 64'(imem_req_valid), 64'd1);
      chk_ok("stall_addr", imem_addr === 32'h8000_0004, 64'(imem_addr), 64'h8000_0004);
      step();
    end
    `CHK("stall_req_valid_end", imem_req_valid, 1'b1);
    `CHK("stall_ir_kept", ir, 32'h0050_0093);
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    step();                                   // accepted -> FETCH_WAIT (wait 1)
    imem_req_ready = 1'b0;
    `CHK("stall_accepted", imem_req_valid, 1'b0);

    // Timeout: response withheld for 4 wait cycles
    step(); step(); step();                   // wait 2, 3, 4
    `CHK("to_not_yet", halt, 1'b0);
    step();                                   // HALT
    chk_ok("to_halt", halt === 1'b1, 64'(halt), 64'd1);
    chk_ok("to_code", halt_code === 2'b11, 64'(halt_code), 64'd3);
    `CHK("to_cycle", cycle_cnt, 64'd13);
    run = 1'b1;
    step(); step();
    run = 1'b0;
    `CHK("to_sticky", halt, 1'b1);
    `CHK("to_cycle_frozen", cycle_cnt, 64'd13);
    `CHK("to_instret_frozen", instret, 64'd1);
    `CHK("to_no_req", imem_req_valid, 1'b0);

    // ebreak
    do_reset();
    `CHK("rst2_halt", halt, 1'b0);
    run = 1'b1; imem_req_ready = 1'b1;
    step();                                   // FETCH_REQ
    run = 1'b0;
    step();                                   // FETCH_WAIT
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
    step();                                   // DECODE
    imem_rsp_valid = 1'b0;
    `CHK("ebk_rf_ren", rf_ren, 1'b0);
    step();                                   // HALT
    chk_ok("ebk_halt", halt === 1'b1, 64'(halt), 64'd1);
    chk_ok("ebk_code", halt_code === 2'b01, 64'(halt_code), 64'd1);
    `CHK("ebk_pc", pc, 32'h8000_0000);
    `CHK("ebk_instret", instret, 64'd1);
    `CHK("ebk_cycle", cycle_cnt, 64'd3);
    for (int i = 0; i < 3; i++) begin
      `CHK("ebk_no_req", imem_req_valid, 1'b0);
      `CHK("ebk_no_wen", rf_wen, 1'b0);
      step();
    end

    // Illegal (add)
    do_reset();
    run = 1'b1; imem_req_ready = 1'b1;
    step();
    run = 1'b0;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
    step();                                   // DECODE
    imem_rsp_valid = 1'b0;
    `CHK("ill_rf_ren", rf_ren, 1'b0);
    step();
    `CHK("ill_halt", halt, 1'b1);
    chk_ok("ill_code", halt_code === 2'b10, 64'(halt_code), 64'd2);
    `CHK("ill_instret", instret, 64'd0);

    // Response on the 4th wait cycle beats the timeout
    do_reset();
    run = 1'b1; imem_req_ready = 1'b1;
    step();                                   // FETCH_REQ
    run = 1'b0;
    step();                                   // wait 1
    imem_req_ready = 1'b0;
    step(); step(); step();                   // wait 2, 3, 4
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    `CHK("late_no_halt", halt, 1'b0);
    step();                                   // DECODE
    imem_rsp_valid = 1'b0;
    `CHK("late_halt", halt, 1'b0);
    `CHK("late_rf_ren", rf_ren, 1'b1);
    `CHK("late_ir", ir, 32'h0050_0093);
    step();                                   // EXEC

    // Reset in EXEC
    reset = 1'b0;
    step();                                   // IDLE
    reset = 1'b1;
    `CHK("mid_req_valid", imem_req_valid, 1'b0);
    `CHK("mid_pc", pc, 32'h8000_0000);
    `CHK("mid_cycle", cycle_cnt, 64'd0);
    `CHK("mid_instret", instret, 64'd0);
    `CHK("mid_wen", rf_wen, 1'b0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
    step();                                   // stray response in IDLE
    imem_rsp_valid = 1'b0;
    `CHK("stray_ir", ir, 32'h0);
    `CHK("stray_req", imem_req_valid, 1'b0);
    `CHK("stray_cycle", cycle_cnt, 64'd0);

    // addi x0,x0,1: no register write
    exu_npc = 32'h8000_0004;
    run = 1'b1; imem_req_ready = 1'b1;
    step();
    run = 1'b0;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0013;
    step();                                   // DECODE
    imem_rsp_valid = 1'b0;
    `CHK("x0_rf_ren", rf_ren, 1'b1);
    step();                                   // EXEC
    step();                                   // WB
    chk_ok("x0_rf_wen", rf_wen === 1'b0, 64'(rf_wen), 64'd0);
    step();                                   // FETCH_REQ
    `CHK("x0_pc", pc, 32'h8000_0004);
    `CHK("x0_instret", instret, 64'd1);
    `CHK("x0_halt", halt, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`undef CHK

// File: doc/core_seq.md
# core_seq

Multi-cycle sequencer for the NPC core. It fetches each instruction from instruction memory over a valid/ready request and valid response handshake, and drives register-file read and write strobes through a fixed decode/execute/writeback sequence. It updates the PC from the datapath's next-PC, and halts on ebreak, an illegal instruction, or a fetch timeout. It sits between the instruction memory port and the existing PC register, register file and adder datapath, replacing the free-running fetch-every-cycle behaviour.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h80000000, PC value after reset
- TIMEOUT, 255, max cycles in FETCH_WAIT without a response
- CNT_W, 64, width of cycle/instret counters

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
- run  in  1  start request, sampled only in IDLE
- imem_req_valid  out  XLEN? no: 1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  instruction data valid
- imem_rsp_data  in  32  instruction word
- exu_npc  in  XLEN  next PC from datapath, sampled in WB
- ir  out  32  latched instruction
- pc  out  XLEN  current PC
- rf_ren  out  1  register-file read strobe
- rf_wen  out  1  register-file write strobe
- halt  out  1  sticky halted flag
- halt_code  out  2  reason: 00 none, 01 ebreak, 10 illegal, 11 fetch timeout
- cycle_cnt  out  CNT_W  active-cycle counter
- instret  out  CNT_W  retired-instruction counter

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB, HALT.
- Reset values:
  - state=IDLE, pc=RESET_PC, ir=0.
  - All strobes are 0; halt=0, halt_code=00; counters and timeout counter are 0.
- IDLE:
  - Go to FETCH_REQ when run=1.
  - run is ignored in every other state.
- FETCH_REQ:
  - imem_req_valid=1 and imem_addr=pc, held stable until imem_req_ready=1.
  - On acceptance, go to FETCH_WAIT with the timeout counter cleared.
  - imem_rsp_valid is ignored in this state.
- FETCH_WAIT:
  - On imem_rsp_valid=1: latch ir<=imem_rsp_data, go to DECODE.
  - Otherwise increment the timeout counter.
  - When the counter equals TIMEOUT and rsp_valid=0: go to HALT with code 11.
  - A response arriving in the same cycle as the timeout condition wins.
- DECODE:
  - Classify ir:
    - ebreak (32'h00100073) → HALT, code 01; instret+1; pc unchanged.
    - addi (opcode 7'b0010011, funct3 000) → EXEC, with rf_ren=1 for this cycle.
    - Anything else → HALT, code 10; no retire.
- EXEC: one cycle for datapath settle; no strobes.
- WB:
  - rf_wen=1 only if ir[11:7]!=0.
  - pc<=exu_npc, instret+1, go to FETCH_REQ.
- HALT:
  - Terminal until reset. halt=1; all strobes 0; counters frozen.
- cycle_cnt: increments every cycle whose state is neither IDLE nor HALT; wraps modulo 2^CNT_W.
- instret: wraps modulo 2^CNT_W.

## Timing
- All outputs are registered or are a pure decode of the state register; no combinational path from imem inputs to imem_req_valid.
- Minimum addi latency is 5 cycles (FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB), with ready high and the response one cycle after acceptance.
- Each added cycle of req-stall or response wait adds one cycle.
- rf_ren and rf_wen are single-cycle pulses per instruction.
- pc changes only on the WB→FETCH_REQ edge; imem_addr is stable throughout FETCH_REQ.
- Reset mid-operation returns to IDLE the next cycle. A late response for the aborted fetch arrives in IDLE or FETCH_REQ and is ignored.
- halt and halt_code assert the cycle after the DECODE or FETCH_WAIT decision and stay until reset.

## Structure
- Shared package core_pkg holds:
  - the state enum;
  - OPC_OP_IMM, F3_ADDI and INST_EBREAK constants;
  - halt-code constants (HALT_NONE/EBREAK/ILLEGAL/TIMEOUT).
- One combinational sub-module, core_decode: ir → {is_addi, is_ebreak, illegal, rd_nz}. It is reused when further instructions are added.
- The FSM, pc register, timeout counter and the two perf counters live in core_seq.

## Test plan
- Reset then run=1, ready=1, response one cycle later with 32'h00500093 (addi x1,x0,5), exu_npc=pc+4:
  - rf_wen pulses 4 cycles after the request cycle;
  - pc=0x80000004 after WB; instret=1; cycle_cnt=5.
- Fetch of 32'h00100073:
  - halt=1, halt_code=01, pc stays 0x80000000, instret=1;
  - no rf_wen; imem_req_valid stays 0 afterwards.
- Fetch of 32'h00000033 (add): halt_code=10, instret=0, no rf_ren.
- TIMEOUT=4, response withheld: halt_code=11 after 4 wait cycles. A repeat run with rsp_valid on the 4th wait cycle proceeds to DECODE instead.
- ready held 0 for 3 cycles: imem_req_valid and imem_addr are held constant, and the request is accepted on the cycle ready=1.
- reset=0 asserted in EXEC: next cycle state=IDLE, pc=0x80000000, counters 0. A stray rsp_valid in IDLE is ignored; addi x0,x0,1 later produces no rf_wen.
